// File: rtl/painterengine_gpu_dma_pkg.sv
// Shared definitions for the GPU DMA reader and writer: FSM states, error codes,
// AXI constants and the one-hot router decoder.
package painterengine_gpu_dma_pkg;

  typedef enum logic [3:0] {
    ST_ROUTING = 4'd0,
    ST_PARAM   = 4'd1,
    ST_CALC    = 4'd2,
    ST_CALC2   = 4'd3,
    ST_AW      = 4'd4,
    ST_W       = 4'd5,
    ST_B       = 4'd6,
    ST_DONE    = 4'd7,
    ST_ERROR   = 4'd8
  } dma_state_e;

  typedef enum logic [2:0] {
    ERR_OK         = 3'd0,
    ERR_ROUTER     = 3'd1,
    ERR_ADDRESS    = 3'd2,
    ERR_AW_TIMEOUT = 3'd3,
    ERR_W_TIMEOUT  = 3'd4,
    ERR_PROTOCOL   = 3'd5,
    ERR_B_TIMEOUT  = 3'd6
  } dma_error_e;

  localparam logic [2:0] SIZE_4B          = 3'b010;
  localparam logic [1:0] BURST_INCR       = 2'b01;
  localparam logic [3:0] CACHE_BUFFERABLE = 4'b0010;

  typedef struct packed {
    logic       valid;
    logic [1:0] index;
  } route_t;

  // Exactly one bit set selects a channel; anything else is a routing error.
  function automatic route_t router_decode(input logic [3:0] router);
    route_t r;
    r.valid = 1'b1;
    r.index = 2'd0;
    case (router)
      4'b0001: r.index = 2'd0;
      4'b0010: r.index = 2'd1;
      4'b0100: r.index = 2'd2;
      4'b1000: r.index = 2'd3;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/painterengine_gpu_dma_burst_calc.sv
// Two-stage registered burst length computation: a burst is limited by the words left
// in the job and by the distance to the next MAX_BURST*4-byte boundary.
module painterengine_gpu_dma_burst_calc #(
  parameter int MAX_BURST = 256,
  localparam int IDX_BITS = $clog2(MAX_BURST),
  localparam int BL_BITS  = IDX_BITS + 1
) (
  input  logic               i_wire_clock,
  input  logic               i_wire_resetn,
  input  logic               i_wire_stage1,
  input  logic               i_wire_stage2,
  input  logic [31:0]        i_wire_address,
  input  logic [31:0]        i_wire_offset,
  input  logic [31:0]        i_wire_length,
  output logic [BL_BITS-1:0] o_wire_burstlen
);

  localparam logic [BL_BITS-1:0] MAX_BURST_V = BL_BITS'(MAX_BURST);

  logic [IDX_BITS-1:0] unalign_reg;
  logic [BL_BITS-1:0]  burstlen_reg;
  logic [BL_BITS-1:0]  aligned_next;
  logic [31:0]         remaining_next;
  logic                unused_address;

  assign aligned_next   = MAX_BURST_V - {1'b0, unalign_reg};
  assign remaining_next = i_wire_length - i_wire_offset;
  assign unused_address = ^{i_wire_address[31:IDX_BITS+2], i_wire_address[1:0]};

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      unalign_reg  <= '0;
      burstlen_reg <= '0;
    end else begin
      // Word index inside the boundary window wraps naturally at IDX_BITS.
      if (i_wire_stage1)
        unalign_reg <= i_wire_address[IDX_BITS+1:2] + i_wire_offset[IDX_BITS-1:0];
      if (i_wire_stage2)
        burstlen_reg <= (remaining_next < 32'(aligned_next)) ?
                        remaining_next[BL_BITS-1:0] : aligned_next;
    end
  end

  assign o_wire_burstlen = burstlen_reg;

endmodule

// File: rtl/painterengine_gpu_dma_writer.sv
// AXI4 write-master DMA: streams one routed GPU source into boundary-safe INCR bursts.
// Define PAINTERENGINE_GPU_DMA_WRITER_BRESP_CHECK_EN to turn non-OKAY BRESP into an error.
module painterengine_gpu_dma_writer
  import painterengine_gpu_dma_pkg::*;
#(
  parameter int TIMEOUT_BITS = 19,
  parameter int MAX_BURST    = 256
) (
  input  logic         i_wire_clock,
  input  logic         i_wire_resetn,
  output logic         o_wire_done,
  output logic         o_wire_error,
  output logic [2:0]   o_wire_error_type,
  input  logic [127:0] i_wire_address,
  input  logic [127:0] i_wire_length,
  input  logic [3:0]   i_wire_router,
  input  logic [127:0] i_wire_data,
  input  logic [3:0]   i_wire_data_valid,
  output logic [3:0]   o_wire_data_next,
  output logic         o_wire_M_AXI_AWID,
  output logic [31:0]  o_wire_M_AXI_AWADDR,
  output logic [7:0]   o_wire_M_AXI_AWLEN,
  output logic [2:0]   o_wire_M_AXI_AWSIZE,
  output logic [1:0]   o_wire_M_AXI_AWBURST,
  output logic         o_wire_M_AXI_AWLOCK,
  output logic [3:0]   o_wire_M_AXI_AWCACHE,
  output logic [2:0]   o_wire_M_AXI_AWPROT,
  output logic [3:0]   o_wire_M_AXI_AWQOS,
  output logic         o_wire_M_AXI_AWVALID,
  input  logic         i_wire_M_AXI_AWREADY,
  output logic [31:0]  o_wire_M_AXI_WDATA,
  output logic [3:0]   o_wire_M_AXI_WSTRB,
  output logic         o_wire_M_AXI_WLAST,
  output logic         o_wire_M_AXI_WVALID,
  input  logic         i_wire_M_AXI_WREADY,
  input  logic         i_wire_M_AXI_BID,
  input  logic [1:0]   i_wire_M_AXI_BRESP,
  input  logic         i_wire_M_AXI_BVALID,
  output logic         o_wire_M_AXI_BREADY
);

  localparam int BL_BITS = $clog2(MAX_BURST) + 1;

  dma_state_e         state_reg;
  dma_error_e         error_type_reg;
  logic [1:0]         sel_reg;
  logic [31:0]        address_reg;
  logic [31:0]        length_reg;
  logic [31:0]        offset_reg;
  logic [BL_BITS-1:0] beat_reg;
  logic [TIMEOUT_BITS-1:0] stall_reg;
  logic               awvalid_reg;

  logic [BL_BITS-1:0] burstlen;
  logic [BL_BITS-1:0] last_beat_index;
  logic [31:0]        offset_next;
  route_t             route;
  logic               in_w;
  logic               src_valid;
  logic               w_fire;
  logic               last_beat;
  logic               stalled;
  logic               bresp_bad;
  logic               unused_b;

  painterengine_gpu_dma_burst_calc #(
    .MAX_BURST (MAX_BURST)
  ) u_burst_calc (
    .i_wire_clock    (i_wire_clock),
    .i_wire_resetn   (i_wire_resetn),
    .i_wire_stage1   (state_reg == ST_CALC),
    .i_wire_stage2   (state_reg == ST_CALC2),
    .i_wire_address  (address_reg),
    .i_wire_offset   (offset_reg),
    .i_wire_length   (length_reg),
    .o_wire_burstlen (burstlen)
  );

  assign route           = router_decode(i_wire_router);
  assign in_w            = (state_reg == ST_W);
  assign src_valid       = i_wire_data_valid[sel_reg];
  assign w_fire          = in_w && src_valid && i_wire_M_AXI_WREADY;
  assign last_beat_index = burstlen - BL_BITS'(1);
  assign last_beat       = (beat_reg == last_beat_index);
  assign offset_next     = offset_reg + 32'(burstlen);
  assign stalled         = stall_reg[TIMEOUT_BITS-1];

`ifdef PAINTERENGINE_GPU_DMA_WRITER_BRESP_CHECK_EN
  assign bresp_bad = (i_wire_M_AXI_BRESP != 2'b00);
  assign unused_b  = i_wire_M_AXI_BID;
`else
  assign bresp_bad = 1'b0;
  assign unused_b  = ^{i_wire_M_AXI_BID, i_wire_M_AXI_BRESP};
`endif

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state_reg      <= ST_ROUTING;
      error_type_reg <= ERR_OK;
      sel_reg        <= 2'd0;
      address_reg    <= '0;
      length_reg     <= '0;
      offset_reg     <= '0;
      beat_reg       <= '0;
      stall_reg      <= '0;
      awvalid_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_ROUTING: begin
          if (route.valid) begin
            sel_reg     <= route.index;
            address_reg <= i_wire_address[{route.index, 5'd0} +: 32];
            length_reg  <= i_wire_length[{route.index, 5'd0} +: 32];
            state_reg   <= ST_PARAM;
          end else begin
            error_type_reg <= ERR_ROUTER;
            state_reg      <= ST_ERROR;
          end
        end
        ST_PARAM: begin
          if (address_reg[1:0] != 2'b00 || length_reg == 32'd0) begin
            error_type_reg <= ERR_ADDRESS;
            state_reg      <= ST_ERROR;
          end else begin
            offset_reg <= '0;
            state_reg  <= ST_CALC;
          end
        end
        ST_CALC:  state_reg <= ST_CALC2;
        ST_CALC2: begin
          awvalid_reg <= 1'b1;
          stall_reg   <= '0;
          state_reg   <= ST_AW;
        end
        ST_AW: begin
          if (stalled) begin
            awvalid_reg    <= 1'b0;
            error_type_reg <= ERR_AW_TIMEOUT;
            state_reg      <= ST_ERROR;
          end else if (i_wire_M_AXI_AWREADY) begin
            awvalid_reg <= 1'b0;
            beat_reg    <= '0;
            stall_reg   <= '0;
            state_reg   <= ST_W;
          end else begin
            stall_reg <= stall_reg + 1'b1;
          end
        end
        ST_W: begin
          if (stalled) begin
            error_type_reg <= ERR_W_TIMEOUT;
            state_reg      <= ST_ERROR;
          end else if (w_fire) begin
            stall_reg <= '0;
            if (last_beat) state_reg <= ST_B;
            else           beat_reg  <= beat_reg + 1'b1;
          end else begin
            stall_reg <= stall_reg + 1'b1;
          end
        end
        ST_B: begin
          if (stalled) begin
            error_type_reg <= ERR_B_TIMEOUT;
            state_reg      <= ST_ERROR;
          end else if (i_wire_M_AXI_BVALID) begin
            stall_reg <= '0;
            if (bresp_bad) begin
              error_type_reg <= ERR_PROTOCOL;
              state_reg      <= ST_ERROR;
            end else begin
              offset_reg <= offset_next;
              state_reg  <= (offset_next >= length_reg) ? ST_DONE : ST_CALC;
            end
          end else begin
            stall_reg <= stall_reg + 1'b1;
          end
        end
        ST_DONE:  state_reg <= ST_DONE;
        ST_ERROR: state_reg <= ST_ERROR;
        default: begin
          error_type_reg <= ERR_PROTOCOL;
          state_reg      <= ST_ERROR;
        end
      endcase
    end
  end

  // Only the routed channel ever sees a pop, and only while beats can move.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_data_next
      assign o_wire_data_next[gi] = in_w && (sel_reg == 2'(gi)) && i_wire_M_AXI_WREADY;
    end
  endgenerate

  assign o_wire_done       = (state_reg == ST_DONE);
  assign o_wire_error      = (state_reg == ST_ERROR);
  assign o_wire_error_type = error_type_reg;

  assign o_wire_M_AXI_AWID    = 1'b0;
  assign o_wire_M_AXI_AWADDR  = address_reg + {offset_reg[29:0], 2'b00};
  assign o_wire_M_AXI_AWLEN   = 8'(last_beat_index);
  assign o_wire_M_AXI_AWSIZE  = SIZE_4B;
  assign o_wire_M_AXI_AWBURST = BURST_INCR;
  assign o_wire_M_AXI_AWLOCK  = 1'b0;
  assign o_wire_M_AXI_AWCACHE = CACHE_BUFFERABLE;
  assign o_wire_M_AXI_AWPROT  = 3'b000;
  assign o_wire_M_AXI_AWQOS   = 4'b0000;
  assign o_wire_M_AXI_AWVALID = awvalid_reg;

  assign o_wire_M_AXI_WDATA  = i_wire_data[{sel_reg, 5'd0} +: 32];
  assign o_wire_M_AXI_WSTRB  = 4'hF;
  assign o_wire_M_AXI_WLAST  = in_w && last_beat;
  assign o_wire_M_AXI_WVALID = in_w && src_valid;

  assign o_wire_M_AXI_BREADY = (state_reg == ST_B);

endmodule

// File: tb/tb_painterengine_gpu_dma_writer.sv
// Directed bench for the GPU DMA writer with a simple AXI slave and counting sources.
module tb_painterengine_gpu_dma_writer;

  localparam int TO_BITS = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         resetn;
  logic         done, error;
  logic [2:0]   error_type;
  logic [127:0] address, length, data;
  logic [3:0]   router, data_valid, data_next;
  logic         awid, awlock, awvalid, awready;
  logic [31:0]  awaddr, wdata;
  logic [7:0]   awlen;
  logic [2:0]   awsize, awprot;
  logic [1:0]   awburst, bresp;
  logic [3:0]   awcache, awqos, wstrb;
  logic         wlast, wvalid, wready, bid, bvalid, bready;

  painterengine_gpu_dma_writer #(.TIMEOUT_BITS(TO_BITS), .MAX_BURST(256)) dut (
    .i_wire_clock(clk), .i_wire_resetn(resetn),
    .o_wire_done(done), .o_wire_error(error), .o_wire_error_type(error_type),
    .i_wire_address(address), .i_wire_length(length), .i_wire_router(router),
    .i_wire_data(data), .i_wire_data_valid(data_valid), .o_wire_data_next(data_next),
    .o_wire_M_AXI_AWID(awid), .o_wire_M_AXI_AWADDR(awaddr), .o_wire_M_AXI_AWLEN(awlen),
    .o_wire_M_AXI_AWSIZE(awsize), .o_wire_M_AXI_AWBURST(awburst), .o_wire_M_AXI_AWLOCK(awlock),
    .o_wire_M_AXI_AWCACHE(awcache), .o_wire_M_AXI_AWPROT(awprot), .o_wire_M_AXI_AWQOS(awqos),
    .o_wire_M_AXI_AWVALID(awvalid), .i_wire_M_AXI_AWREADY(awready),
    .o_wire_M_AXI_WDATA(wdata), .o_wire_M_AXI_WSTRB(wstrb), .o_wire_M_AXI_WLAST(wlast),
    .o_wire_M_AXI_WVALID(wvalid), .i_wire_M_AXI_WREADY(wready),
    .i_wire_M_AXI_BID(bid), .i_wire_M_AXI_BRESP(bresp), .i_wire_M_AXI_BVALID(bvalid),
    .o_wire_M_AXI_BREADY(bready)
  );

  int checks = 0;
  int failures = 0;

  // Slave / source model state
  logic        aw_ready_en = 1'b1;
  logic [1:0]  bresp_val = 2'b00;
  logic        src_valid = 1'b1;
  logic [31:0] src_idx = '0;
  int          stall_at = -1, stall_left = 0;
  bit          stall_done = 0, b_pending = 0, outstanding = 0, awvalid_seen = 0;
  int          aw_count = 0, w_total = 0, b_count = 0, burst_beat = 0;
  int          wlast_err = 0, ovl_err = 0, next_err = 0, invalid_err = 0, stall_cycles = 0;
  logic [7:0]  cur_len = '0;
  logic [31:0] aw_addr_q[$];
  logic [7:0]  aw_len_q[$];
  logic [31:0] wdata_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Responder: drive inputs on the falling edge, sample what the next rising edge will see.
  initial begin
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (stall_left == 0 && !stall_done && w_total == stall_at) begin
          stall_left = 10;
          stall_done = 1;
        end
        if (stall_left > 0) begin
          src_valid = 1'b0;
          stall_left--;
        end else begin
          src_valid = 1'b1;
        end
      end
      for (int k = 0; k < 4; k++) data[k*32 +: 32] = {8'(k), src_idx[23:0]};
      data_valid = {4{src_valid}};
      awready = aw_ready_en;
      wready  = 1'b1;
      bvalid  = b_pending;
      bresp   = bresp_val;
      #1;
      if (resetn) begin
        if (awvalid) awvalid_seen = 1;
        if ((data_next & ~router) != 4'b0) next_err++;
        if (!src_valid) begin
          stall_cycles++;
          if (wvalid) invalid_err++;
        end
        if (awvalid && awready) begin
          if (outstanding) ovl_err++;
          outstanding = 1;
          aw_count++;
          aw_addr_q.push_back(awaddr);
          aw_len_q.push_back(awlen);
          cur_len = awlen;
          burst_beat = 0;
        end
        if (wvalid && wready) begin
          wdata_q.push_back(wdata);
          if (wlast !== (burst_beat == int'(cur_len))) wlast_err++;
          burst_beat++;
          w_total++;
          if (wlast) b_pending = 1;
        end
        if (|(data_next & data_valid)) src_idx++;
        if (bvalid && bready) begin
          b_count++;
          outstanding = 0;
          b_pending = 0;
        end
      end
    end
  end

  task automatic start_job(input logic [3:0] rt, input logic [31:0] addr, input logic [31:0] len,
                           input int stall_beat, input logic aw_en, input logic [1:0] resp);
    @(negedge clk);
    #3;
    resetn = 1'b0;
    router = rt;
    for (int k = 0; k < 4; k++) begin
      address[k*32 +: 32] = rt[k] ? addr : (32'hBAD0_0001 + 32'(k));
      length[k*32 +: 32]  = rt[k] ? len : 32'd7;
    end
    aw_ready_en = aw_en; bresp_val = resp; stall_at = stall_beat;
    stall_left = 0; stall_done = 0; b_pending = 0; outstanding = 0; awvalid_seen = 0;
    src_idx = '0; aw_count = 0; w_total = 0; b_count = 0; burst_beat = 0;
    wlast_err = 0; ovl_err = 0; next_err = 0; invalid_err = 0; stall_cycles = 0;
    aw_addr_q.delete(); aw_len_q.delete(); wdata_q.delete();
    repeat (2) @(negedge clk);
    #3;
    resetn = 1'b1;
  endtask

  task automatic wait_end(input string tag, input int bound);
    int n = 0;
    while (!(done || error) && n < bound) begin
      @(negedge clk);
      #3;
      n++;
    end
    check({tag, "_finished"}, 32'(done | error), 32'd1);
  endtask

  task automatic check_data(input string tag, input logic [7:0] ch, input int n);
    int bad = 0;
    if (wdata_q.size() != n) bad++;
    for (int i = 0; i < wdata_q.size(); i++)
      if (wdata_q[i] !== {ch, 24'(i)}) bad++;
    check({tag, "_data_bad"}, 32'(bad), 32'd0);
  endtask

  initial begin
    resetn = 1'b0; router = 4'b0010; address = '0; length = '0;
    data = '0; data_valid = '0; awready = 1'b0; wready = 1'b0;
    bid = 1'b0; bresp = 2'b00; bvalid = 1'b0;
    #2;
    check("reset_outputs", {20'b0, awvalid, wvalid, wlast, bready, data_next, done, error, error_type},
          32'd0);

    // Single 3-beat burst on channel 1
    start_job(4'b0010, 32'h0000_1000, 32'd3, -1, 1'b1, 2'b00);
    wait_end("t1", 500);
    check("t1_done", {31'b0, done}, 32'd1);
    check("t1_error_type", {29'b0, error_type}, 32'd0);
    check("t1_aw_count", 32'(aw_count), 32'd1);
    check("t1_awaddr", aw_addr_q.size() > 0 ? aw_addr_q[0] : 32'hFFFF_FFFF, 32'h0000_1000);
    check("t1_awlen", aw_len_q.size() > 0 ? 32'(aw_len_q[0]) : 32'hFFFF_FFFF, 32'd2);
    check("t1_beats", 32'(w_total), 32'd3);
    check("t1_wlast_err", 32'(wlast_err), 32'd0);
    check("t1_b_count", 32'(b_count), 32'd1);
    check("t1_next_err", 32'(next_err), 32'd0);
    check_data("t1", 8'd1, 3);
    check("t1_constants", {10'b0, awid, awsize, awburst, awlock, awcache, awprot, awqos, wstrb},
          {10'b0, 1'b0, 3'b010, 2'b01, 1'b0, 4'b0010, 3'b000, 4'b0000, 4'hF});

    // Boundary split: 0x3F8, 4 words -> 2 beats + 2 beats
    start_job(4'b0001, 32'h0000_03F8, 32'd4, -1, 1'b1, 2'b00);
    wait_end("t2", 500);
    check("t2_done", {31'b0, done}, 32'd1);
    check("t2_aw_count", 32'(aw_count), 32'd2);
    check("t2_awaddr0", aw_addr_q.size() > 0 ? aw_addr_q[0] : 32'hFFFF_FFFF, 32'h0000_03F8);
    check("t2_awlen0", aw_len_q.size() > 0 ? 32'(aw_len_q[0]) : 32'hFFFF_FFFF, 32'd1);
    check("t2_awaddr1", aw_addr_q.size() > 1 ? aw_addr_q[1] : 32'hFFFF_FFFF, 32'h0000_0400);
    check("t2_awlen1", aw_len_q.size() > 1 ? 32'(aw_len_q[1]) : 32'hFFFF_FFFF, 32'd1);
    check("t2_overlap", 32'(ovl_err), 32'd0);
    check("t2_wlast_err", 32'(wlast_err), 32'd0);
    check_data("t2", 8'd0, 4);

    // 600 words from 0 on channel 3 with a 10-cycle source stall at beat 100
    start_job(4'b1000, 32'h0000_0000, 32'd600, 100, 1'b1, 2'b00);
    wait_end("t3", 3000);
    check("t3_done", {31'b0, done}, 32'd1);
    check("t3_aw_count", 32'(aw_count), 32'd3);
    check("t3_awaddr0", aw_addr_q.size() > 0 ? aw_addr_q[0] : 32'hFFFF_FFFF, 32'h0000_0000);
    check("t3_awlen0", aw_len_q.size() > 0 ? 32'(aw_len_q[0]) : 32'hFFFF_FFFF, 32'd255);
    check("t3_awaddr1", aw_addr_q.size() > 1 ? aw_addr_q[1] : 32'hFFFF_FFFF, 32'h0000_0400);
    check("t3_awlen1", aw_len_q.size() > 1 ? 32'(aw_len_q[1]) : 32'hFFFF_FFFF, 32'd255);
    check("t3_awaddr2", aw_addr_q.size() > 2 ? aw_addr_q[2] : 32'hFFFF_FFFF, 32'h0000_0800);
    check("t3_awlen2", aw_len_q.size() > 2 ? 32'(aw_len_q[2]) : 32'hFFFF_FFFF, 32'd87);
    check("t3_beats", 32'(w_total), 32'd600);
    check("t3_stall_cycles", 32'(stall_cycles), 32'd10);
    check("t3_wvalid_in_stall", 32'(invalid_err), 32'd0);
    check("t3_wlast_err", 32'(wlast_err), 32'd0);
    check("t3_overlap", 32'(ovl_err), 32'd0);
    check("t3_next_err", 32'(next_err), 32'd0);
    check_data("t3", 8'd3, 600);

    // Invalid router
    start_job(4'b0011, 32'h0000_1000, 32'd3, -1, 1'b1, 2'b00);
    wait_end("t4", 50);
    check("t4_error", {31'b0, error}, 32'd1);
    check("t4_error_type", {29'b0, error_type}, 32'd1);
    repeat (5) @(negedge clk);
    check("t4_no_awvalid", {31'b0, awvalid_seen}, 32'd0);

    // Misaligned address
    start_job(4'b0100, 32'h0000_1002, 32'd3, -1, 1'b1, 2'b00);
    wait_end("t5", 50);
    check("t5_error", {31'b0, error}, 32'd1);
    check("t5_error_type", {29'b0, error_type}, 32'd2);
    repeat (5) @(negedge clk);
    check("t5_no_awvalid", {31'b0, awvalid_seen}, 32'd0);

    // AWREADY held low until the stall counter MSB sets
    start_job(4'b0001, 32'h0000_0040, 32'd4, -1, 1'b0, 2'b00);
    wait_end("t6", 2000);
    check("t6_error_type", {29'b0, error_type}, 32'd3);
    check("t6_aw_count", 32'(aw_count), 32'd0);
    check("t6_awvalid_dropped", {31'b0, awvalid}, 32'd0);

    // SLVERR response
    start_job(4'b0100, 32'h0000_0080, 32'd2, -1, 1'b1, 2'b10);
    wait_end("t7", 500);
    check("t7_b_count", 32'(b_count), 32'd1);
`ifdef PAINTERENGINE_GPU_DMA_WRITER_BRESP_CHECK_EN
    check("t7_error", {31'b0, error}, 32'd1);
    check("t7_error_type", {29'b0, error_type}, 32'd5);
`else
    check("t7_done", {31'b0, done}, 32'd1);
    check("t7_error_type", {29'b0, error_type}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/painterengine_gpu_dma_writer.md
Name: painterengine_gpu_dma_writer

Overview:
AXI4 full write-master DMA for the GPU. It is the write-side counterpart of the GPU DMA read path. It takes a 32-bit word stream from one of four one-hot-routed GPU sources and writes it to memory as INCR bursts. Bursts never cross a 256-beat (1 KiB) boundary, and only one burst is outstanding at a time. It reports done or error, with an error-type code, to the GPU control logic.

Parameters:
TIMEOUT_BITS, 19, width of the stall counter; MSB set means timeout.
MAX_BURST, 256, maximum beats per burst; the alignment boundary is MAX_BURST*4 bytes.

Ports:
i_wire_clock  in  1  clock
i_wire_resetn  in  1  asynchronous active-low reset
o_wire_done  out  1  high while in DONE
o_wire_error  out  1  high while in ERROR
o_wire_error_type  out  3  error code (see Behaviour)
i_wire_address  in  4*32  per-channel byte start address; channel k at [k*32+:32]
i_wire_length  in  4*32  per-channel length in 32-bit words
i_wire_router  in  4  one-hot channel select; held stable for the whole job
i_wire_data  in  4*32  per-channel source data
i_wire_data_valid  in  4  per-channel source valid
o_wire_data_next  out  4  per-channel pop; only the selected bit is ever driven, the others stay 0
o_wire_M_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWLOCK/AWCACHE/AWPROT/AWQOS/AWVALID  out  1/32/8/3/2/1/4/3/4/1  AXI AW channel
i_wire_M_AXI_AWREADY  in  1  AXI AW ready
o_wire_M_AXI_WDATA/WSTRB/WLAST/WVALID  out  32/4/1/1  AXI W channel
i_wire_M_AXI_WREADY  in  1  AXI W ready
i_wire_M_AXI_BID/BRESP/BVALID  in  1/2/1  AXI B channel
o_wire_M_AXI_BREADY  out  1  AXI B ready

Behaviour:
- Clock and reset: one clock, i_wire_clock. i_wire_resetn is asynchronous and active-low. Reset clears all registers and returns to ROUTING, including mid-burst; no AXI transaction is completed.
- Reset values of outputs: AWVALID=0, WVALID=0, WLAST=0, BREADY=0, data_next=0, done=0, error=0, error_type=0.
- Constant outputs: AWID=0, AWSIZE=3'b010, AWBURST=INCR, AWLOCK=0, AWCACHE=4'b0010, AWPROT=0, AWQOS=0, WSTRB=4'hF.
- Error codes: 0 ok, 1 router, 2 address, 3 AW timeout, 4 W timeout, 5 protocol, 6 B timeout.
- Stall counter: increments each cycle a handshake is pending (AW, W or B) and clears on each handshake. When its MSB is set in AW/W/B state, go to ERROR with code 3/4/6 respectively.
- ERROR and DONE are sticky until reset.
- State ROUTING: the router value selects channel index 0..3 and latches address and length. Any other router value -> ERROR, code 1.
- State PARAM: address[1:0]!=0 or length==0 -> ERROR, code 2. Otherwise offset=0 -> CALC.
- State CALC (1 cycle): unalign = address[9:2]+offset[7:0], 8-bit wrap.
- State CALC2 (1 cycle): remaining = length-offset; aligned = MAX_BURST-unalign (9 bits); burstlen = min(aligned, remaining).
- State AW:
  - AWADDR = address + offset*4, AWLEN = burstlen-1, AWVALID=1.
  - On AWVALID&&AWREADY: drop AWVALID, clear the beat counter -> W.
- State W:
  - WDATA = selected channel's i_wire_data, combinational.
  - WVALID = selected data_valid.
  - data_next[sel] = WREADY.
  - WLAST = (beat==burstlen-1).
  - A beat transfers when WVALID&&WREADY. On the last beat -> B; otherwise beat+1.
  - Source valid low only stalls (counted by the timeout).
- State B:
  - BREADY=1.
  - On BVALID, offset += burstlen; then if offset >= length -> DONE, else -> CALC.
  - BRESP handling: see Optional Feature.
- Outside W, data_next and WVALID are 0. Outside B, BREADY is 0.
- Worked boundary example: address 0x3F8, length 4 gives two bursts, 2 beats at 0x3F8 then 2 beats at 0x400.

Optional Feature:
PAINTERENGINE_GPU_DMA_WRITER_BRESP_CHECK_EN
- Defined: in state B, BVALID with BRESP!=2'b00 -> ERROR, code 5, and offset is not advanced.
- Undefined: BRESP is ignored, and every B response advances as OKAY.

Decomposition:
- Shared package: state encodings (4-bit, 9 states), error-type codes (3-bit), AXI constants (SIZE_4B, BURST_INCR, CACHE_BUFFERABLE). Both the DMA reader and writer use the same package.
- One sub-module: painterengine_gpu_dma_burst_calc. It is a registered two-stage computation of burstlen from address, offset and length, shared with the reader.

Test Plan:
- Router 4'b0010, ch1 address 0x1000, length 3; slave always ready; source always valid -> one AW with AWADDR 0x1000, AWLEN 2; 3 W beats with WLAST on beat 3; one B; done=1; data_next only on bit 1.
- Address 0x3F8, length 4 -> AW at 0x3F8 with AWLEN 1, then AW at 0x400 with AWLEN 1; second AW only after the first B; done.
- Length 600 at 0x0 -> bursts of 256, 256 and 88 beats at 0x0, 0x400 and 0x800.
- Router 4'b0011 -> error=1, type 1. Address 0x1002 -> error=1, type 2. In both cases no AWVALID is ever asserted.
- Source valid low for 10 cycles mid-burst -> WVALID low for those cycles, with no lost or duplicated word (data checked against an incrementing pattern). Holding AWREADY low for 2^18 cycles -> error type 3.
- With the macro defined, BRESP=2'b10 -> error type 5. Without the macro, the same stimulus -> done.
